// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per
//               clock, LSB first, through a single registered borrow stage.
//               Optional signed-overflow flag enabled by defining the macro
//               SERIAL_SUBTRACTOR_OVF_EN; without it ovf is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic               w_x;
  logic               w_y;
  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_res_nxt;

  // Start is honoured in IDLE and DONE only; RUN ignores it entirely.
  assign w_accept = start && (r_state != RUN);
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == c_last);

  // Full-subtractor slice on the current operand LSBs.
  assign w_x       = r_a[0];
  assign w_y       = r_b[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_nxt  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, LSB-first shifting and result publication on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_nxt;
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + c_one;
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_br_nxt;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_amsb;
  logic r_bmsb;
  logic r_ovf;

  // Signed overflow: operand signs differ and the result sign differs from a.
  // The final difference bit is the result MSB, so w_d is used directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_amsb <= a[WIDTH-1];
      r_bmsb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = w_run;
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
`default_nettype wire
